alu_seq: RTL

Sequential execution ALU for the multi-cycle CPU datapath, and the consumer of the 3-bit ALU control code produced by the ALU control decoder. It takes operands plus a control code through a start/done handshake. Logic, add, subtract and set-less-than complete in one cycle; multiply runs on an iterative shift-add engine with fixed latency. It sits in the EX stage and stalls the pipeline controller via `busy_o` while a multiply is in flight.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_mul_iter.sv | 64 ++++++
 rtl/alu_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and sequencer state encoding
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_MUL = 3'd3;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one partial product per step
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] acc_sum;

  // product_o already includes the current step, so the caller can take it on the last step edge
  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign acc_sum   = acc_q + addend;
  assign product_o = acc_sum;
  assign last_o    = (cnt_q == '0);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH - 1);
    end else if (step_i) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - EX-stage ALU: single-cycle logic/arith ops plus fixed-latency multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  alu_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;

  logic             mul_load;
  logic             mul_step;
  logic             mul_last;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] alu_res;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (mul_load),
    .step_i   (mul_step),
    .a_i      (data1_i),
    .b_i      (data2_i),
    .last_o   (mul_last),
    .product_o(mul_prod)
  );

  // Codes 4/5 and MUL fall to zero here; MUL never takes this path
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_AND: alu_res = data1_i & data2_i;
      ALU_OR:  alu_res = data1_i | data2_i;
      ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB: alu_res = data1_i - data2_i;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;
    zero_d   = zero_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == ALU_MUL) begin
            mul_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = MUL;
          end else begin
            data_d = alu_res;
            zero_d = (alu_res == '0);
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          data_d  = mul_prod;
          zero_d  = (mul_prod == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign data_o = data_q;
  assign zero_o = zero_q;

endmodule
